// File: rtl/dadda16_seq_ctrl.sv
// 16x16 unsigned/signed multiplier sequencer built around one external 8x8 unsigned array.
// Four partial products are accumulated on magnitudes; the sign is restored in a final FIX cycle.
module dadda16_seq_ctrl #(
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_signed,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        busy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_y
);

  typedef enum logic [2:0] {
    StIdle,
    StCalc0,
    StCalc1,
    StCalc2,
    StCalc3,
    StFix,
    StDone
  } state_e;

  state_e      state_q;
  logic [15:0] ma_q;
  logic [15:0] mb_q;
  logic        neg_q;
  logic [31:0] acc_q;

  logic        signed_mode;
  logic [15:0] abs_a;
  logic [15:0] abs_b;
  logic [31:0] partial;

  // |0x8000| wraps back to 0x8000, which is the correct 16-bit unsigned magnitude.
  assign signed_mode = SIGNED_EN && in_signed;
  assign abs_a       = (signed_mode && in_a[15]) ? (~in_a + 16'd1) : in_a;
  assign abs_b       = (signed_mode && in_b[15]) ? (~in_b + 16'd1) : in_b;

  assign in_ready = (state_q == StIdle);
  assign busy     = (state_q != StIdle);

  // Byte-lane selection for the shared array and alignment of its result.
  always_comb begin
    mul_a   = 8'h00;
    mul_b   = 8'h00;
    partial = 32'h0;
    case (state_q)
      StCalc0: begin
        mul_a   = ma_q[7:0];
        mul_b   = mb_q[7:0];
        partial = {16'h0, mul_y};
      end
      StCalc1: begin
        mul_a   = ma_q[15:8];
        mul_b   = mb_q[7:0];
        partial = {8'h0, mul_y, 8'h0};
      end
      StCalc2: begin
        mul_a   = ma_q[7:0];
        mul_b   = mb_q[15:8];
        partial = {8'h0, mul_y, 8'h0};
      end
      StCalc3: begin
        mul_a   = ma_q[15:8];
        mul_b   = mb_q[15:8];
        partial = {mul_y, 16'h0};
      end
      default: begin
        mul_a   = 8'h00;
        mul_b   = 8'h00;
        partial = 32'h0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ma_q      <= 16'h0;
      mb_q      <= 16'h0;
      neg_q     <= 1'b0;
      acc_q     <= 32'h0;
      out_valid <= 1'b0;
      out_p     <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            ma_q    <= abs_a;
            mb_q    <= abs_b;
            neg_q   <= signed_mode & (in_a[15] ^ in_b[15]);
            acc_q   <= 32'h0;
            state_q <= StCalc0;
          end
        end
        StCalc0: begin
          acc_q   <= acc_q + partial;
          state_q <= StCalc1;
        end
        StCalc1: begin
          acc_q   <= acc_q + partial;
          state_q <= StCalc2;
        end
        StCalc2: begin
          acc_q   <= acc_q + partial;
          state_q <= StCalc3;
        end
        StCalc3: begin
          acc_q   <= acc_q + partial;
          state_q <= StFix;
        end
        StFix: begin
          // Negating a zero magnitude yields zero, so no special case is needed.
          out_p     <= neg_q ? (~acc_q + 32'd1) : acc_q;
          out_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dadda16_seq_ctrl.sv
// Scoreboard bench: a signed-capable and an unsigned-only instance see identical stimulus and
// are checked against a plain-arithmetic product model.
module tb_dadda16_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_signed;
  logic        out_ready;

  logic        in_ready_s, out_valid_s, busy_s;
  logic [31:0] out_p_s;
  logic [7:0]  mul_a_s, mul_b_s;
  logic [15:0] mul_y_s;

  logic        in_ready_u, out_valid_u, busy_u;
  logic [31:0] out_p_u;
  logic [7:0]  mul_a_u, mul_b_u;
  logic [15:0] mul_y_u;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_s[$];
  logic [31:0] exp_u[$];

  always #5 clk = ~clk;

  assign mul_y_s = 16'(mul_a_s) * 16'(mul_b_s);
  assign mul_y_u = 16'(mul_a_u) * 16'(mul_b_u);

  dadda16_seq_ctrl #(.SIGNED_EN(1'b1)) u_dut_s (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_p     (out_p_s),
    .busy      (busy_s),
    .mul_a     (mul_a_s),
    .mul_b     (mul_b_s),
    .mul_y     (mul_y_s)
  );

  dadda16_seq_ctrl #(.SIGNED_EN(1'b0)) u_dut_u (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_u),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .out_valid (out_valid_u),
    .out_ready (out_ready),
    .out_p     (out_p_u),
    .busy      (busy_u),
    .mul_a     (mul_a_u),
    .mul_b     (mul_b_u),
    .mul_y     (mul_y_u)
  );

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                           input bit s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[31:0];
  endfunction

  function automatic logic [15:0] mag(input logic [15:0] a, input bit s);
    int v;
    v = s ? int'($signed(a)) : int'(a);
    if (v < 0) v = -v;
    return v[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected product whenever an output handshake happens.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset_n && out_valid_s && out_ready) begin
      if (exp_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_s: got %h expected no output", out_p_s);
      end else begin
        e = exp_s.pop_front();
        check("product_s", out_p_s, e);
      end
    end
    if (reset_n && out_valid_u && out_ready) begin
      if (exp_u.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_u: got %h expected no output", out_p_u);
      end else begin
        e = exp_u.pop_front();
        check("product_u", out_p_u, e);
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int t = 0;
    while (!in_ready_s && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    ok = in_ready_s;
    if (!ok) check("ready_timeout", {31'h0, in_ready_s}, 32'h1);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit s,
                       input int hold, input bit pulse);
    bit ok;
    logic [15:0] ma, mb;
    logic [15:0] pr[4];
    logic [31:0] held;
    wait_ready(ok);
    if (!ok) return;
    @(negedge clk);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    exp_s.push_back(ref_prod(a, b, s));
    exp_u.push_back(ref_prod(a, b, 1'b0));
    #1;
    in_valid  = 1'b0;
    in_a      = 16'($urandom);
    in_b      = 16'($urandom);
    in_signed = 1'($urandom);
    ma = mag(a, s);
    mb = mag(b, s);
    pr[0] = {ma[7:0], mb[7:0]};
    pr[1] = {ma[15:8], mb[7:0]};
    pr[2] = {ma[7:0], mb[15:8]};
    pr[3] = {ma[15:8], mb[15:8]};
    for (int k = 0; k < 4; k++) begin
      check("mul_ab", {16'h0, mul_a_s, mul_b_s}, {16'h0, pr[k]});
      check("busy_calc", {31'h0, busy_s}, 32'h1);
      @(posedge clk);
      #1;
    end
    check("valid_fix", {30'h0, out_valid_s, out_valid_u}, 32'h0);
    check("mul_fix", {16'h0, mul_a_s, mul_b_s}, 32'h0);
    @(posedge clk);
    #1;
    check("valid_done", {30'h0, out_valid_s, out_valid_u}, 32'h3);
    check("mul_done", {16'h0, mul_a_s, mul_b_s}, 32'h0);
    held = out_p_s;
    if (pulse) in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_stable", out_p_s, held);
      check("hold_flags", {28'h0, out_valid_s, in_ready_s, busy_s, in_ready_u}, 32'hA);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("back_idle", {28'h0, in_ready_s, out_valid_s, busy_s, in_ready_u}, 32'h9);
    out_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [15:0] corner[6];
    logic [15:0] ra, rb;
    corner[0] = 16'h0000;
    corner[1] = 16'h8000;
    corner[2] = 16'hFFFF;
    corner[3] = 16'h7FFF;
    corner[4] = 16'h0001;
    corner[5] = 16'hFF00;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_flags", {28'h0, in_ready_s, out_valid_s, busy_s, in_ready_u}, 32'h9);
    check("reset_mul", {16'h0, mul_a_s, mul_b_s}, 32'h0);
    check("reset_p", out_p_s, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    do_op(16'h1234, 16'h5678, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1, 1'b0);
    do_op(16'h0000, 16'hABCD, 1'b0, 0, 1'b0);
    do_op(16'hFFFD, 16'h0005, 1'b1, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b1, 0, 1'b0);
    do_op(16'h8000, 16'h0001, 1'b1, 2, 1'b0);
    do_op(16'hFFFF, 16'h0002, 1'b1, 0, 1'b0);
    do_op(16'h0000, 16'hFFFF, 1'b1, 0, 1'b0);
    do_op(16'h4321, 16'h0007, 1'b0, 5, 1'b1);

    // Abort an operation in CALC2; its product must never appear.
    wait_ready(ok);
    @(negedge clk);
    in_a      = 16'h1234;
    in_b      = 16'h5678;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("abort_calc2_mul", {16'h0, mul_a_s, mul_b_s}, 32'h3456);
    reset_n = 1'b0;
    #1;
    check("abort_flags", {28'h0, in_ready_s, out_valid_s, busy_s, in_ready_u}, 32'h9);
    check("abort_mul", {16'h0, mul_a_s, mul_b_s}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    do_op(16'h0002, 16'h0003, 1'b0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
      do_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    repeat (10) @(posedge clk);
    #1;
    check("queue_s_empty", 32'(exp_s.size()), 32'h0);
    check("queue_u_empty", 32'(exp_u.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dadda16_seq_ctrl.md
Name: dadda16_seq_ctrl

Overview:
- Sequencer that computes 16x16 products (unsigned or two's-complement signed) by time-multiplexing one external 8x8 unsigned dadda multiplier over four cycles.
- Accepts operands on a valid/ready input handshake and returns a 32-bit product on a valid/ready output handshake.
- Sits between the vector/scalar execute stage and the shared 8x8 dadda array. It drives the array's A/B inputs and consumes its combinational 16-bit result in the same cycle.

Parameters:
- SIGNED_EN, 1, when 0 the in_signed port is ignored and all operations are unsigned.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept an operand pair.
- in_a  input  16  multiplicand.
- in_b  input  16  multiplier.
- in_signed  input  1  1 = two's-complement operands.
- out_valid  output  1  product available.
- out_ready  input  1  consumer takes the product.
- out_p  output  32  product.
- busy  output  1  high in any state other than IDLE.
- mul_a  output  8  to the 8x8 multiplier A input.
- mul_b  output  8  to the 8x8 multiplier B input.
- mul_y  input  16  from the 8x8 multiplier, combinational in the same cycle.

Behaviour:
- Clock is clk, single domain. reset_n is asynchronous and active-low.
- Reset state: state=IDLE, accumulator=0, out_valid=0, out_p=0, busy=0, mul_a=0, mul_b=0. in_ready=1 because in_ready = (state==IDLE).
- States are IDLE, CALC0, CALC1, CALC2, CALC3, FIX, DONE.
- IDLE: on the in_valid && in_ready edge:
  - Latch magnitude registers ma=|in_a| and mb=|in_b| when signed mode is active (in_signed && SIGNED_EN); otherwise latch raw values.
  - Latch neg = signed_mode & (in_a[15]^in_b[15]).
  - Clear the accumulator and go to CALC0.
- Magnitudes are 16-bit unsigned. |0x8000| = 0x8000, with no overflow.
- CALCk drives mul_a/mul_b combinationally and, on the edge, adds mul_y shifted by the amount below into the 32-bit accumulator:
  - CALC0: ma[7:0] x mb[7:0], shift 0.
  - CALC1: ma[15:8] x mb[7:0], shift 8.
  - CALC2: ma[7:0] x mb[15:8], shift 8.
  - CALC3: ma[15:8] x mb[15:8], shift 16.
- Accumulation is modulo 2^32. Overflow cannot occur, since the magnitude product is at most 0xFFFE0001.
- mul_a and mul_b are 0 in IDLE, FIX and DONE.
- FIX: out_p <= neg ? (~acc + 1) : acc, out_valid <= 1, next state DONE.
- Latency: out_valid is high after the 6th rising edge counting the accept edge as the 1st (accept, CALC0..3, FIX).
- DONE: out_p and out_valid are held stable while out_ready=0. On the out_valid && out_ready edge: out_valid <= 0, next state IDLE. out_p keeps its last value.
- Throughput is one operation per 7 cycles minimum. No new operand is accepted in DONE.
- in_valid while busy is ignored (in_ready=0). Operand inputs are sampled only on the accept edge, so later changes have no effect.
- Zero operands need no special handling. A zero product is never negated to a nonzero value, because -0 = 0.
- When reset_n is asserted mid-operation, all state clears immediately (asynchronously). An in-flight product is discarded and never presented.
- SIGNED_EN=0: neg is always 0 and magnitudes are the raw inputs.

Test Plan:
- Unsigned: in_a=0x1234, in_b=0x5678, in_signed=0, out_ready=1 → mul_a/mul_b sequence (0x34,0x78), (0x12,0x78), (0x34,0x56), (0x12,0x56). out_p=0x06260060, with out_valid high after the 6th edge including the accept edge.
- Unsigned extreme: 0xFFFF x 0xFFFF, in_signed=0 → out_p=0xFFFE0001. Also 0x0000 x 0xABCD → 0x00000000.
- Signed: 0xFFFD (-3) x 0x0005, in_signed=1 → out_p=0xFFFFFFF1. Also 0x8000 x 0x8000 → 0x40000000, and 0x8000 x 0x0001 → 0xFFFF8000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → out_p stable, in_ready=0, busy=1. A new in_valid pulse in that window is not accepted. On out_ready=1, IDLE follows one edge later and in_ready=1.
- Reset mid-op: assert reset_n=0 during CALC2 → out_valid=0, busy=0, in_ready=1, mul_a=mul_b=0 immediately with no clock edge. The aborted product never appears. A following 0x0002 x 0x0003 → out_p=0x00000006.
- SIGNED_EN=0 build: 0xFFFF x 0x0002 with in_signed=1 → out_p=0x0001FFFE (treated as unsigned).
